stream_downsize: RTL and testbench

//  Width-reducing stream converter: splits each wide input beat of T_DATA_RATIO lanes into

---
 rtl/stream_downsize.sv | 91 +++++++++
 tb/tb_stream_downsize.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: serializes each wide beat into lanes, lane 0 first.
// Define STREAM_DOWNSIZE_SPARSE_KEEP_EN to honour s_keep_i and skip masked lanes.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]          s_keep_i,
  input  logic                             s_last_i,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  output logic [T_DATA_WIDTH-1:0]          m_data_o,
  output logic                             m_last_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i
);

  localparam int W = T_DATA_WIDTH;
  localparam int R = T_DATA_RATIO;
  localparam logic [R-1:0] ONE = {{(R-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, SEND} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [W*R-1:0]   data_q;
  logic [R-1:0]     rem_q;
  logic [R-1:0]     rem_d;
  logic             last_q;
  logic [R-1:0]     keep_eff;
  logic [R-1:0]     rem_new;
  logic [R-1:0]     cur_oh;
  logic             one_hot;
  logic             fire;
  logic             accept;

`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
  assign keep_eff = s_keep_i;
`else
  // keep is ignored; the OR only keeps the port read
  assign keep_eff = s_keep_i | {R{1'b1}};
`endif

  // an all-masked last beat still emits lane 0 to carry the boundary
  assign rem_new = (keep_eff == '0 && s_last_i) ? ONE : keep_eff;

  assign cur_oh  = rem_q & (~rem_q + ONE);
  assign one_hot = (rem_q != '0) && (rem_q == cur_oh);
  assign fire    = m_valid_o & m_ready_i;
  assign accept  = s_valid_i & s_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (accept) begin
        data_q <= s_data_i;
        last_q <= s_last_i;
      end
    end
  end

  always_comb begin
    rem_d = rem_q;
    if (fire)
      rem_d = rem_q & ~cur_oh;
    if (accept)
      rem_d = rem_new;
    state_d = (rem_d != '0) ? SEND : EMPTY;
  end

  always_comb begin
    m_valid_o = (state_q == SEND);
    m_data_o  = '0;
    for (int k = 0; k < R; k++) begin
      if (m_valid_o && cur_oh[k])
        m_data_o = data_q[k*W +: W];
    end
    m_last_o  = m_valid_o & last_q & one_hot;
    s_ready_o = !rst & ((state_q == EMPTY) |
                (m_valid_o & m_ready_i & one_hot));
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: directed cases plus a random run
// scored against a lane-serializing queue model.
module tb_stream_downsize;

  localparam int W = 4;
  localparam int R = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [W*R-1:0] s_data_i;
  logic [R-1:0]   s_keep_i;
  logic           s_last_i;
  logic           s_valid_i;
  logic           s_ready_o;
  logic [W-1:0]   m_data_o;
  logic           m_last_o;
  logic           m_valid_o;
  logic           m_ready_i;

  stream_downsize #(
    .T_DATA_WIDTH(W),
    .T_DATA_RATIO(R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data_i),
    .s_keep_i (s_keep_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } lane_t;

  lane_t q[$];
  int total = 0;
  int bad = 0;
  int slast_cnt = 0;
  int mlast_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: which lanes a wide beat turns into
  task automatic push_beat(input logic [W*R-1:0] d,
                           input logic [R-1:0] keep,
                           input logic last);
    logic [R-1:0] k;
    int hi;
    lane_t e;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
    k = keep;
`else
    k = '1;
    if (keep == 2'b11) k = '1;
`endif
    if (k == '0 && last) k[0] = 1'b1;
    hi = -1;
    for (int j = 0; j < R; j++)
      if (k[j]) hi = j;
    for (int j = 0; j < R; j++) begin
      if (k[j]) begin
        e.d = d[j*W +: W];
        e.l = last && (j == hi);
        q.push_back(e);
      end
    end
    if (last && hi >= 0) slast_cnt++;
  endtask

  logic         stall = 1'b0;
  logic [W-1:0] hd;
  logic         hl;

  always @(negedge clk) begin
    lane_t e;
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_v", m_valid_o, 1);
        check("hold_d", m_data_o, hd);
        check("hold_l", m_last_o, hl);
      end
      if (!m_valid_o) begin
        if (m_data_o !== '0 || m_last_o !== 1'b0)
          check("idle_out", {m_last_o, m_data_o}, 0);
      end
      if (m_valid_o && m_ready_i) begin
        if (q.size() == 0) begin
          check("unexp_out", q.size(), 1);
        end else begin
          e = q.pop_front();
          check("data", m_data_o, e.d);
          check("last", m_last_o, e.l);
        end
        if (m_last_o) mlast_cnt++;
      end
      stall = m_valid_o && !m_ready_i;
      hd = m_data_o;
      hl = m_last_o;
      if (s_valid_i && s_ready_o)
        push_beat(s_data_i, s_keep_i, s_last_i);
    end
  end

  task automatic present(input logic [7:0] d,
                         input logic [1:0] k,
                         input logic l);
    s_data_i  = d;
    s_keep_i  = k;
    s_last_i  = l;
    s_valid_i = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    int s0;
    int m0;
    logic took;

    rst = 1'b1;
    s_valid_i = 1'b0;
    s_data_i = '0;
    s_keep_i = '0;
    s_last_i = 1'b0;
    m_ready_i = 1'b1;
    @(negedge clk);
    check("rst_valid", m_valid_o, 0);
    check("rst_ready", s_ready_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_last", m_last_o, 0);
    step();
    rst = 1'b0;

    // 1: single beat, latency one
    step();
    present(8'hA5, 2'b11, 1'b0);
    @(negedge clk);
    check("t1_rdy", s_ready_o, 1);
    check("t1_v0", m_valid_o, 0);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t1_v1", m_valid_o, 1);
    check("t1_d0", m_data_o, 4'h5);
    check("t1_l0", m_last_o, 0);
    @(negedge clk);
    check("t1_d1", m_data_o, 4'hA);
    check("t1_l1", m_last_o, 0);
    @(negedge clk);
    check("t1_v2", m_valid_o, 0);

    // 2: back-to-back wide beats
    step();
    present(8'h21, 2'b11, 1'b0);
    step();
    present(8'h43, 2'b11, 1'b1);
    @(negedge clk);
    check("t2_d1", m_data_o, 4'h1);
    check("t2_rdy0", s_ready_o, 0);
    @(negedge clk);
    check("t2_d2", m_data_o, 4'h2);
    check("t2_rdy1", s_ready_o, 1);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t2_d3", m_data_o, 4'h3);
    check("t2_l3", m_last_o, 0);
    @(negedge clk);
    check("t2_d4", m_data_o, 4'h4);
    check("t2_l4", m_last_o, 1);
    @(negedge clk);
    check("t2_idle", m_valid_o, 0);

    // 3: sink stall
    step();
    m_ready_i = 1'b0;
    present(8'hA5, 2'b11, 1'b0);
    step();
    s_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_d", m_data_o, 4'h5);
      check("t3_rdy", s_ready_o, 0);
    end
    step();
    m_ready_i = 1'b1;
    @(negedge clk);
    check("t3_d0", m_data_o, 4'h5);
    @(negedge clk);
    check("t3_d1", m_data_o, 4'hA);
    @(negedge clk);
    check("t3_idle", m_valid_o, 0);

    // 4: partial keep
    step();
    present(8'h70, 2'b10, 1'b1);
    step();
    s_valid_i = 1'b0;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
    @(negedge clk);
    check("t4_d", m_data_o, 4'h7);
    check("t4_l", m_last_o, 1);
    @(negedge clk);
    check("t4_idle", m_valid_o, 0);
    step();
    present(8'h5A, 2'b00, 1'b0);
    @(negedge clk);
    check("t4_zrdy", s_ready_o, 1);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t4_zv", m_valid_o, 0);
    check("t4_zrdy2", s_ready_o, 1);
    step();
    present(8'h5A, 2'b00, 1'b1);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t4_zl_d", m_data_o, 4'hA);
    check("t4_zl_l", m_last_o, 1);
`else
    @(negedge clk);
    check("t4_d0", m_data_o, 4'h0);
    check("t4_l0", m_last_o, 0);
    @(negedge clk);
    check("t4_d1", m_data_o, 4'h7);
    check("t4_l1", m_last_o, 1);
`endif
    step();
    step();

    // 5: reset mid-beat
    present(8'hA5, 2'b11, 1'b0);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t5_d0", m_data_o, 4'h5);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rv", m_valid_o, 0);
    check("t5_rr", s_ready_o, 0);
    check("t5_rd", m_data_o, 0);
    step();
    rst = 1'b0;
    step();
    present(8'h21, 2'b11, 1'b0);
    step();
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t5_d1", m_data_o, 4'h1);
    @(negedge clk);
    check("t5_d2", m_data_o, 4'h2);
    @(negedge clk);
    check("t5_idle", m_valid_o, 0);

    // 6: random run
    step();
    s0 = slast_cnt;
    m0 = mlast_cnt;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      took = s_valid_i && s_ready_o;
      if (took) sent++;
      step();
      cyc++;
      m_ready_i = ($urandom_range(0, 3) != 0);
      if (!s_valid_i || took) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0)
          present(8'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0));
        else
          s_valid_i = 1'b0;
      end
    end
    check("rnd_sent", sent, 1000);
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || m_valid_o) && cyc < 100) begin
      step();
      cyc++;
    end
    @(negedge clk);
    check("rnd_drain", q.size(), 0);
    check("rnd_lastcnt", mlast_cnt - m0, slast_cnt - s0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
